// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - opcode constants and state encoding for counter_ctrl
package counter_ctrl_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_UP   = 2'b10;
  localparam logic [1:0] OP_DOWN = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EXEC = 1'b1;

  function automatic logic op_counts(input logic [1:0] op);
    return (op == OP_UP) || (op == OP_DOWN);
  endfunction

endpackage

// File: rtl/counter_ctrl_step_timer.sv
// rtl/counter_ctrl_step_timer.sv - loadable down-counter of remaining EXEC cycles
module step_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  input  logic             clear,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Saturates at zero so a stray decrement can never wrap to the maximum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load_en) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - command-driven sequencer for an external up/down/load counter
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic             abort,
  output logic             enable,
  output logic             mode,
  output logic             activeLoad,
  output logic [WIDTH-1:0] load,
  output logic             busy,
  output logic             done
);

  logic [0:0]       state;
  logic [1:0]       op_q;
  logic             accept;
  logic             quit;
  logic             finish;
  logic             timer_dec;
  logic             timer_zero;
  logic             arg_counts;
  logic [WIDTH-1:0] extra_steps;

  assign accept     = (state == ST_IDLE) && cmd_valid && !abort;
  assign quit       = (state == ST_EXEC) && abort;
  assign finish     = (state == ST_EXEC) && !abort && timer_zero;
  assign timer_dec  = (state == ST_EXEC) && !abort;
  assign arg_counts = op_counts(cmd_op) && (cmd_arg != '0);

  // The timer holds the EXEC cycles still to come after the current one.
  assign extra_steps = ((cmd_op == OP_LOAD) || (cmd_arg == '0)) ? '0 : cmd_arg - 1'b1;

  step_timer #(.WIDTH(WIDTH)) u_step_timer (
    .clk      (clk),
    .rst      (rst),
    .load_en  (accept),
    .load_val (extra_steps),
    .dec      (timer_dec),
    .clear    (quit),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      op_q       <= OP_HOLD;
      enable     <= 1'b0;
      mode       <= 1'b1;
      activeLoad <= 1'b0;
      load       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cmd_ready  <= 1'b1;
    end else begin
      done <= 1'b0;
      if (accept) begin
        state      <= ST_EXEC;
        op_q       <= cmd_op;
        busy       <= 1'b1;
        cmd_ready  <= 1'b0;
        enable     <= arg_counts;
        activeLoad <= (cmd_op == OP_LOAD);
        if (cmd_op == OP_LOAD) begin
          load <= cmd_arg;
        end
        // Direction only changes when the counter will actually step.
        if (arg_counts) begin
          mode <= (cmd_op == OP_UP);
        end
      end else if (quit || finish) begin
        state      <= ST_IDLE;
        busy       <= 1'b0;
        cmd_ready  <= 1'b1;
        enable     <= 1'b0;
        activeLoad <= 1'b0;
        done       <= finish;
      end else if (state == ST_EXEC) begin
        enable     <= op_counts(op_q);
        activeLoad <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - self-checking bench for counter_ctrl
module tb_counter_ctrl;
  import counter_ctrl_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_arg;
  logic         abort;
  logic         enable;
  logic         mode;
  logic         activeLoad;
  logic [W-1:0] load;
  logic         busy;
  logic         done;

  logic [W-1:0] cnt;
  logic         mode_m;
  logic [W-1:0] load_m;
  logic [W-1:0] cnt_m;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] arg;
    int           abort_after;
    int           cycles;
    int           done_n;
    logic [W-1:0] cnt;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  counter_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .abort      (abort),
    .enable     (enable),
    .mode       (mode),
    .activeLoad (activeLoad),
    .load       (load),
    .busy       (busy),
    .done       (done)
  );

  // External counter steered by the controller outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else if (activeLoad) cnt <= load;
    else if (enable) cnt <= mode ? cnt + 1'b1 : cnt - 1'b1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] arg, input int abort_after,
                         input int exp_cycles, input int exp_done, input logic [W-1:0] exp_cnt,
                         input string name);
    int   len;
    int   n_busy;
    int   n_done;
    int   bad;
    logic en_exp;
    len    = ((op == OP_LOAD) || (arg == 0)) ? 1 : int'(arg);
    en_exp = ((op == OP_UP) || (op == OP_DOWN)) && (arg != 0);
    n_busy = 0;
    n_done = 0;
    bad    = 0;
    if (en_exp) mode_m = (op == OP_UP);
    if (op == OP_LOAD) load_m = arg;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int c = 0; c < len + 3; c++) begin
      @(negedge clk);
      abort = 1'b0;
      if (busy) begin
        n_busy++;
        if (enable !== en_exp || activeLoad !== (op == OP_LOAD) || cmd_ready !== 1'b0 ||
            done !== 1'b0 || mode !== mode_m || load !== load_m) bad++;
        if (n_busy == abort_after) abort = 1'b1;
      end else begin
        if (done) n_done++;
        if (enable !== 1'b0 || activeLoad !== 1'b0 || cmd_ready !== 1'b1 ||
            mode !== mode_m || load !== load_m) bad++;
      end
    end
    abort = 1'b0;
    check({name, " exec_cycles"}, n_busy, exp_cycles);
    check({name, " done_pulses"}, n_done, exp_done);
    check({name, " bad_cycles"}, bad, 0);
    check({name, " cnt"}, int'(cnt), int'(exp_cnt));
    check({name, " cmd_ready"}, int'(cmd_ready), 1);
    cnt_m = exp_cnt;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   len;
    int   k;
    int   cyc;
    logic [1:0]   r_op;
    logic [W-1:0] r_arg;

    vecs[0]  = '{OP_LOAD, 4'd11, 0, 1,  1, 4'd11};
    vecs[1]  = '{OP_LOAD, 4'd0,  0, 1,  1, 4'd0};
    vecs[2]  = '{OP_UP,   4'd5,  0, 5,  1, 4'd5};
    vecs[3]  = '{OP_LOAD, 4'd1,  0, 1,  1, 4'd1};
    vecs[4]  = '{OP_DOWN, 4'd3,  0, 3,  1, 4'd14};
    vecs[5]  = '{OP_HOLD, 4'd4,  0, 4,  1, 4'd14};
    vecs[6]  = '{OP_UP,   4'd0,  0, 1,  1, 4'd14};
    vecs[7]  = '{OP_DOWN, 4'd0,  0, 1,  1, 4'd14};
    vecs[8]  = '{OP_UP,   4'd15, 0, 15, 1, 4'd13};
    vecs[9]  = '{OP_UP,   4'd15, 4, 4,  0, 4'd1};
    vecs[10] = '{OP_DOWN, 4'd2,  1, 1,  0, 4'd0};
    vecs[11] = '{OP_HOLD, 4'd1,  0, 1,  1, 4'd0};

    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OP_HOLD;
    cmd_arg   = '0;
    abort     = 1'b0;
    mode_m    = 1'b1;
    load_m    = '0;
    cnt_m     = '0;

    #12;
    check("reset cmd_ready", int'(cmd_ready), 1);
    check("reset busy", int'(busy), 0);
    check("reset enable", int'(enable), 0);
    check("reset mode", int'(mode), 1);
    check("reset activeLoad", int'(activeLoad), 0);
    check("reset load", int'(load), 0);
    check("reset done", int'(done), 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_cmd(vecs[i].op, vecs[i].arg, vecs[i].abort_after, vecs[i].cycles,
              vecs[i].done_n, vecs[i].cnt, $sformatf("vec%0d", i));
    end

    // Abort while idle blocks acceptance of a simultaneous command.
    @(negedge clk);
    cmd_valid = 1'b1; abort = 1'b1; cmd_op = OP_UP; cmd_arg = 4'd3;
    @(posedge clk);
    #1 cmd_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("idle_abort busy", int'(busy), 0);
    check("idle_abort cmd_ready", int'(cmd_ready), 1);

    // HOLD 0 then LOAD 3 with cmd_valid held high throughout.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_HOLD; cmd_arg = 4'd0;
    @(posedge clk);
    #1 cmd_op = OP_LOAD; cmd_arg = 4'd3;
    @(negedge clk);
    check("b2b hold busy", int'(busy), 1);
    check("b2b hold enable", int'(enable), 0);
    @(negedge clk);
    check("b2b hold done", int'(done), 1);
    check("b2b hold cmd_ready", int'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("b2b load busy", int'(busy), 1);
    check("b2b load activeLoad", int'(activeLoad), 1);
    check("b2b load value", int'(load), 3);
    @(negedge clk);
    check("b2b load done", int'(done), 1);
    check("b2b cnt", int'(cnt), 3);
    load_m = 4'd3;
    cnt_m  = 4'd3;

    // Reset in the middle of DOWN 10.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_DOWN; cmd_arg = 4'd10;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid busy before reset", int'(busy), 1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst enable", int'(enable), 0);
    check("mid_rst mode", int'(mode), 1);
    check("mid_rst activeLoad", int'(activeLoad), 0);
    check("mid_rst load", int'(load), 0);
    check("mid_rst busy", int'(busy), 0);
    check("mid_rst done", int'(done), 0);
    check("mid_rst cmd_ready", int'(cmd_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_arg = 4'd6;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("post_rst busy", int'(busy), 1);
    check("post_rst activeLoad", int'(activeLoad), 1);
    @(negedge clk);
    check("post_rst done", int'(done), 1);
    check("post_rst cnt", int'(cnt), 6);
    mode_m = 1'b1;
    load_m = 4'd6;
    cnt_m  = 4'd6;

    // Random commands against an arithmetic model of the counter.
    for (int n = 0; n < 24; n++) begin
      r_op  = 2'($urandom_range(0, 3));
      r_arg = W'($urandom_range(0, 15));
      len   = ((r_op == OP_LOAD) || (r_arg == 0)) ? 1 : int'(r_arg);
      k     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len)) : 0;
      cyc   = (k != 0) ? k : len;
      case (r_op)
        OP_LOAD: cnt_m = r_arg;
        OP_UP:   if (r_arg != 0) cnt_m = cnt_m + W'(cyc);
        OP_DOWN: if (r_arg != 0) cnt_m = cnt_m - W'(cyc);
        default: cnt_m = cnt_m;
      endcase
      run_cmd(r_op, r_arg, k, cyc, (k != 0) ? 0 : 1, cnt_m, $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
